// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   rx_state_t         : receiver frame-sequencing states
//   OVERSAMPLE_DEFAULT : default number of sample ticks per bit
//   parity_error()     : parity check of one received frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // data_xor is the XOR-reduction of the received data word. The result is 1
    // when the sampled parity bit does not match the selected parity sense.
    function automatic logic parity_error(input logic sample_bit,
                                          input logic data_xor,
                                          input logic odd);
        return sample_bit ^ data_xor ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : input synchronized to clk_i; both flops reset to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the value from before the edge; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with oversampled start detection and a valid/ready output.
//   Clk_Core    : core clock
//   Rst_Core    : asynchronous active-high reset
//   Clk_Rx      : oversample clock from the baud generator, used as data only
//   Rx_Serial   : serial line, idles high, LSB first
//   Rx_Data     : received word
//   Rx_Valid    : Rx_Data and status flags are valid
//   Rx_Ready    : consumer accepts the held word
//   Parity_Err  : parity mismatch for the held word (0 when parity disabled)
//   Frame_Err   : stop bit sampled low for the held word
//   Overrun_Err : one-cycle pulse when a completed frame is dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 Clk_Core,
    input  logic                 Rst_Core,
    input  logic                 Clk_Rx,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Overrun_Err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD_SENSE = (PARITY_ODD != 0);
    localparam logic              PAR_ON    = (PARITY_EN != 0);

    // ------------------------------------------------------------------
    // Input synchronization and sample tick
    // ------------------------------------------------------------------
    logic rx_s;
    logic clk_rx_s;
    logic clk_rx_d_q;
    logic tick;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk_i (Clk_Core),
        .rst_i (Rst_Core),
        .d_i   (Rx_Serial),
        .q_o   (rx_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_clk_rx (
        .clk_i (Clk_Core),
        .rst_i (Rst_Core),
        .d_i   (Clk_Rx),
        .q_o   (clk_rx_s)
    );

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            clk_rx_d_q <= 1'b0;
        end else begin
            clk_rx_d_q <= clk_rx_s;
        end
    end

    // One Clk_Core cycle per rising edge of the oversample clock.
    assign tick = clk_rx_s & ~clk_rx_d_q;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    rx_state_t            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frame_done;

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end

                START: begin
                    if (tick_cnt_q == MID_TICK) begin
                        // A start bit that is high again at its midpoint was noise.
                        if (!rx_s) begin
                            state_q    <= DATA;
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            par_err_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        // LSB arrives first, so shifting right leaves it in bit 0.
                        shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PAR_ON ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end

                PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        par_err_q  <= parity_error(rx_s, ^shift_q, ODD_SENSE);
                        tick_cnt_q <= '0;
                        state_q    <= STOP;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    // Leave at mid stop bit so a directly following start
                    // edge is still caught.
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded in the stop-sample tick cycle so the output register updates on
    // the same edge, giving Rx_Valid one cycle after the stop sample.
    assign frame_done = tick && (state_q == STOP) && (tick_cnt_q == LAST_TICK);

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_done) begin
                // A new frame may replace the held word only if that word is
                // leaving this cycle; otherwise the new frame is discarded.
                if (!rx_valid_q || Rx_Ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= PAR_ON & par_err_q;
                    frame_err_q  <= ~rx_s;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && Rx_Ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign Rx_Data     = rx_data_q;
    assign Rx_Valid    = rx_valid_q;
    assign Parity_Err  = parity_err_q;
    assign Frame_Err   = frame_err_q;
    assign Overrun_Err = overrun_q;

endmodule
